// File: rtl/rx_bridge_pkg.sv
// rtl/rx_bridge_pkg.sv - shared types and constants for the 16b-to-64b receive bridge
package rx_bridge_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    localparam int FMT_4DW_BIT  = 0;
    localparam int FMT_DATA_BIT = 1;
    localparam int MAX_LEN_DW   = 1024;

    // Lane 0 is the most significant halfword of the assembled word.
    function automatic logic [63:0] put_halfword(input logic [63:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [15:0] hw);
        logic [63:0] r;
        r = word;
        case (lane)
            LANE_0:  r[63:48] = hw;
            LANE_1:  r[47:32] = hw;
            LANE_2:  r[31:16] = hw;
            default: r[15:0]  = hw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rx_len_checker.sv
// rtl/rx_len_checker.sv - header length capture and halfword count compare (RX_BRIDGE_LEN_CHECK_EN)
module rx_len_checker
    import rx_bridge_pkg::*;
(
    input  logic       clk_125,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       close_prev,
    input  logic       close_cur,
    input  logic [1:0] fmt_in,
    input  logic [9:0] len_in,
    output logic       len_err
);

    logic [11:0] cnt;
    logic [11:0] cnt_inc;
    logic [1:0]  fmt;
    logic [9:0]  len;

    function automatic logic mismatch(input logic [11:0] n,
                                      input logic [1:0]  f,
                                      input logic [9:0]  l);
        logic [10:0] len_dw;
        logic [10:0] exp_dw;
        len_dw = (l == 10'd0) ? 11'(MAX_LEN_DW) : {1'b0, l};
        exp_dw = (f[FMT_4DW_BIT] ? 11'd4 : 11'd3) + (f[FMT_DATA_BIT] ? len_dw : 11'd0);
        return n[0] || (n[11:1] != exp_dw);
    endfunction

    assign cnt_inc = (cnt == 12'hFFF) ? cnt : cnt + 12'd1;

    always_ff @(posedge clk_125) begin
        if (rst) begin
            cnt     <= '0;
            fmt     <= '0;
            len     <= '0;
            len_err <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (start) begin
                // The aborted packet is judged on what it had; the new one starts at one halfword.
                if (close_prev) len_err <= mismatch(cnt, fmt, len);
                if (close_cur)  len_err <= mismatch(12'd1, fmt_in, len_in);
                cnt <= 12'd1;
                fmt <= fmt_in;
                len <= '0;
            end else if (cont) begin
                cnt <= cnt_inc;
                if (cnt == 12'd1) len <= len_in;
                if (close_cur) len_err <= mismatch(cnt_inc, fmt, (cnt == 12'd1) ? len_in : len);
            end
        end
    end

endmodule

// File: rtl/rx_bridge_16b_to_64b.sv
// rtl/rx_bridge_16b_to_64b.sv - packs 16-bit RX TLP halfwords into 64-bit words; length check under RX_BRIDGE_LEN_CHECK_EN
module rx_bridge_16b_to_64b
    import rx_bridge_pkg::*;
(
    input  logic        clk_125,
    input  logic        rst,
    input  logic [15:0] rx_data_16b,
    input  logic        rx_st_16b,
    input  logic        rx_end_16b,
    output logic [63:0] rx_data_64b,
    output logic        rx_val_64b,
    output logic        rx_st_64b,
    output logic        rx_end_64b,
    output logic        rx_dwen_64b,
    output logic        rx_err,
    output logic        rx_len_err
);

    state_t      state, state_n;
    logic [1:0]  lane, lane_n;
    logic [63:0] buf_q, buf_n;
    logic [63:0] word_w, start_w;
    logic        first, first_n;
    logic        emit, emit_st, emit_end, emit_dwen, err_n;
    logic [63:0] emit_data;

    assign word_w  = put_halfword(buf_q, lane, rx_data_16b);
    assign start_w = put_halfword(64'd0, LANE_0, rx_data_16b);

    always_comb begin
        state_n   = state;
        lane_n    = lane;
        buf_n     = buf_q;
        first_n   = first;
        emit      = 1'b0;
        emit_data = buf_q;
        emit_st   = first;
        emit_end  = 1'b0;
        emit_dwen = 1'b0;
        err_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_st_16b && rx_end_16b) begin
                    emit      = 1'b1;
                    emit_data = start_w;
                    emit_st   = 1'b1;
                    emit_end  = 1'b1;
                    emit_dwen = 1'b1;
                    err_n     = 1'b1;
                end else if (rx_st_16b) begin
                    buf_n   = start_w;
                    lane_n  = LANE_1;
                    first_n = 1'b1;
                    state_n = ST_COLLECT;
                end else if (rx_end_16b) begin
                    err_n = 1'b1;
                end
            end
            default: begin
                if (rx_st_16b) begin
                    // Missing end: flush what is buffered (lane halfwords) and restart on this beat.
                    emit      = 1'b1;
                    emit_end  = 1'b1;
                    emit_dwen = (lane != LANE_3);
                    err_n     = 1'b1;
                    buf_n     = start_w;
                    lane_n    = LANE_1;
                    first_n   = 1'b1;
                end else begin
                    lane_n = lane + 2'd1;
                    if (rx_end_16b) begin
                        emit      = 1'b1;
                        emit_data = word_w;
                        emit_end  = 1'b1;
                        emit_dwen = (lane == LANE_0) || (lane == LANE_1);
                        err_n     = ~lane[0];
                        state_n   = ST_IDLE;
                        lane_n    = LANE_0;
                        buf_n     = '0;
                        first_n   = 1'b0;
                    end else if (lane == LANE_3) begin
                        emit      = 1'b1;
                        emit_data = word_w;
                        buf_n     = '0;
                        first_n   = 1'b0;
                    end else begin
                        buf_n = word_w;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_125) begin
        if (rst) begin
            state       <= ST_IDLE;
            lane        <= LANE_0;
            buf_q       <= '0;
            first       <= 1'b0;
            rx_data_64b <= '0;
            rx_val_64b  <= 1'b0;
            rx_st_64b   <= 1'b0;
            rx_end_64b  <= 1'b0;
            rx_dwen_64b <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            state      <= state_n;
            lane       <= lane_n;
            buf_q      <= buf_n;
            first      <= first_n;
            rx_val_64b <= emit;
            rx_err     <= err_n;
            if (emit) begin
                rx_data_64b <= emit_data;
                rx_st_64b   <= emit_st;
                rx_end_64b  <= emit_end;
                rx_dwen_64b <= emit_dwen;
            end
        end
    end

`ifdef RX_BRIDGE_LEN_CHECK_EN
    logic in_collect;
    assign in_collect = (state == ST_COLLECT);

    rx_len_checker u_len_checker (
        .clk_125    (clk_125),
        .rst        (rst),
        .start      (rx_st_16b),
        .cont       (in_collect && !rx_st_16b),
        .close_prev (in_collect && rx_st_16b),
        .close_cur  (rx_end_16b && (in_collect ? !rx_st_16b : rx_st_16b)),
        .fmt_in     (rx_data_16b[14:13]),
        .len_in     (rx_data_16b[9:0]),
        .len_err    (rx_len_err)
    );
`else
    assign rx_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_bridge_16b_to_64b.sv
// tb/tb_rx_bridge_16b_to_64b.sv - self-checking bench for rx_bridge_16b_to_64b
module tb_rx_bridge_16b_to_64b;

    logic        clk_125 = 1'b0;
    logic        rst;
    logic [15:0] rx_data_16b;
    logic        rx_st_16b, rx_end_16b;
    logic [63:0] rx_data_64b;
    logic        rx_val_64b, rx_st_64b, rx_end_64b, rx_dwen_64b, rx_err, rx_len_err;

    always #4 clk_125 = ~clk_125;

    rx_bridge_16b_to_64b dut (
        .clk_125     (clk_125),
        .rst         (rst),
        .rx_data_16b (rx_data_16b),
        .rx_st_16b   (rx_st_16b),
        .rx_end_16b  (rx_end_16b),
        .rx_data_64b (rx_data_64b),
        .rx_val_64b  (rx_val_64b),
        .rx_st_64b   (rx_st_64b),
        .rx_end_64b  (rx_end_64b),
        .rx_dwen_64b (rx_dwen_64b),
        .rx_err      (rx_err),
        .rx_len_err  (rx_len_err)
    );

`ifdef RX_BRIDGE_LEN_CHECK_EN
    localparam logic LEN_ON = 1'b1;
`else
    localparam logic LEN_ON = 1'b0;
`endif

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Packet-level model: halfwords of the open word, total packet count, header halfwords.
    logic [15:0] wq[$];
    bit          in_pkt = 0;
    bit          m_first = 0;
    int          total = 0;
    logic [15:0] h0 = '0, h1 = '0;
    logic [63:0] e_data = '0;
    logic        e_val = 0, e_st = 0, e_end = 0, e_dwen = 0, e_err = 0, e_len = 0;

    function automatic logic [63:0] pack_wq();
        logic [63:0] r = '0;
        for (int i = 0; i < wq.size(); i++) r[63-16*i -: 16] = wq[i];
        return r;
    endfunction

    function automatic logic len_mismatch();
        int l, e;
        l = (h1[9:0] == 10'd0) ? 1024 : int'(h1[9:0]);
        e = (h0[13] ? 4 : 3) + (h0[14] ? l : 0);
        return LEN_ON && (((total % 2) != 0) || ((total / 2) != e));
    endfunction

    task automatic m_emit(input logic en, input logic dw, input logic er, input logic ln);
        e_val  = 1'b1;
        e_data = pack_wq();
        e_st   = m_first;
        e_end  = en;
        e_dwen = dw;
        e_err  = er;
        e_len  = ln;
        m_first = 0;
        wq.delete();
    endtask

    always @(posedge clk_125) begin
        bit was;
        e_val = 0; e_err = 0; e_len = 0;
        was = in_pkt;
        if (rst) begin
            in_pkt = 0; m_first = 0; total = 0; wq.delete();
            e_data = '0; e_st = 0; e_end = 0; e_dwen = 0;
        end else if (rx_st_16b) begin
            if (was) m_emit(1'b1, wq.size() <= 2, 1'b1, len_mismatch());
            wq.delete();
            wq.push_back(rx_data_16b);
            total = 1; h0 = rx_data_16b; m_first = 1;
            if (!was && rx_end_16b) begin
                m_emit(1'b1, 1'b1, 1'b1, len_mismatch());
                in_pkt = 0;
            end else in_pkt = 1;
        end else if (was) begin
            wq.push_back(rx_data_16b);
            total++;
            if (total == 2) h1 = rx_data_16b;
            if (rx_end_16b) begin
                m_emit(1'b1, wq.size() <= 2, (total % 2) != 0, len_mismatch());
                in_pkt = 0;
            end else if (wq.size() == 4) begin
                m_emit(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end else if (rx_end_16b) begin
            e_err = 1;
        end
    end

    // Per-cycle compare against the model plus a log of emitted words for literal pins.
    logic [63:0] log_w[$];
    logic [2:0]  log_f[$];
    int          errs = 0, lens = 0;

    always @(negedge clk_125) begin
        chk("val",    rx_val_64b,  e_val);
        chk("err",    rx_err,      e_err);
        chk("lenerr", rx_len_err,  e_len);
        chk("data",   rx_data_64b, e_data);
        chk("st",     rx_st_64b,   e_st);
        chk("end",    rx_end_64b,  e_end);
        chk("dwen",   rx_dwen_64b, e_dwen);
        if (rx_val_64b) begin
            log_w.push_back(rx_data_64b);
            log_f.push_back({rx_st_64b, rx_end_64b, rx_dwen_64b});
        end
        if (rx_err) errs++;
        if (rx_len_err) lens++;
    end

    task automatic clear_log();
        log_w.delete(); log_f.delete(); errs = 0; lens = 0;
    endtask

    task automatic pin_word(input string name, input int i, input logic [63:0] w, input logic [2:0] f);
        if (i < log_w.size()) begin
            chk({name, "_data"}, log_w[i], w);
            chk({name, "_flags"}, {61'd0, log_f[i]}, {61'd0, f});
        end else begin
            checks++;
            $display("FAIL %s: word %0d missing, got %0d words", name, i, log_w.size());
        end
    endtask

    task automatic beat(input logic st, input logic en, input logic [15:0] d);
        rx_st_16b = st; rx_end_16b = en; rx_data_16b = d;
        @(posedge clk_125); #1;
        rx_st_16b = 0; rx_end_16b = 0; rx_data_16b = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_125); #1; end
    endtask

    task automatic send_seq(input int n, input logic [15:0] h0v, input logic [15:0] h1v,
                            input logic [15:0] base, input bit with_end);
        for (int i = 0; i < n; i++)
            beat(i == 0, with_end && (i == n - 1),
                 (i == 0) ? h0v : (i == 1) ? h1v : base + 16'(i));
    endtask

    initial begin
        rst = 1; rx_st_16b = 0; rx_end_16b = 0; rx_data_16b = '0;
        repeat (3) @(posedge clk_125);
        @(negedge clk_125);
        chk("rst_val", rx_val_64b, 0);
        chk("rst_data", rx_data_64b, 0);
        chk("rst_flags", {rx_st_64b, rx_end_64b, rx_dwen_64b, rx_err, rx_len_err}, 0);
        @(posedge clk_125); #1;
        rst = 0;
        idle(2);

        clear_log();
        send_seq(6, 16'h0000, 16'h0001, 16'h0000, 1); idle(3);
        chk("mrd_words", log_w.size(), 2);
        pin_word("mrd_w0", 0, 64'h0000_0001_0002_0003, 3'b100);
        pin_word("mrd_w1", 1, 64'h0004_0005_0000_0000, 3'b011);
        chk("mrd_err", errs, 0);
        chk("mrd_len", lens, 0);

        clear_log();
        send_seq(8, 16'h4000, 16'h0001, 16'h1000, 1); idle(3);
        pin_word("mwr3_w0", 0, 64'h4000_0001_1002_1003, 3'b100);
        pin_word("mwr3_w1", 1, 64'h1004_1005_1006_1007, 3'b010);
        chk("mwr3_len", lens, 0);

        clear_log();
        send_seq(10, 16'h6000, 16'h0001, 16'h2000, 1); idle(3);
        chk("mwr4_words", log_w.size(), 3);
        pin_word("mwr4_w1", 1, 64'h2004_2005_2006_2007, 3'b000);
        pin_word("mwr4_w2", 2, 64'h2008_2009_0000_0000, 3'b011);
        chk("mwr4_len", lens, 0);

        clear_log();
        send_seq(10, 16'h6000, 16'h0002, 16'h2000, 1); idle(3);
        chk("mwr4_badlen", lens, LEN_ON);

        clear_log();
        send_seq(7, 16'h0000, 16'h0001, 16'h3000, 1); idle(3);
        pin_word("odd_w1", 1, 64'h3004_3005_3006_0000, 3'b010);
        chk("odd_err", errs, 1);
        chk("odd_len", lens, LEN_ON);

        clear_log();
        send_seq(5, 16'h0000, 16'h0001, 16'h4000, 0);
        send_seq(6, 16'h0000, 16'h0001, 16'h5000, 1); idle(3);
        chk("trunc_words", log_w.size(), 4);
        pin_word("trunc_w1", 1, 64'h4004_0000_0000_0000, 3'b011);
        pin_word("trunc_w2", 2, 64'h0000_0001_5002_5003, 3'b100);
        pin_word("trunc_w3", 3, 64'h5004_5005_0000_0000, 3'b011);
        chk("trunc_err", errs, 1);
        chk("trunc_len", lens, LEN_ON);

        clear_log();
        beat(1, 0, 16'h0000);
        beat(0, 0, 16'h0001);
        rst = 1;
        beat(0, 0, 16'h7002);
        rst = 0;
        @(negedge clk_125);
        chk("midrst_data", rx_data_64b, 0);
        chk("midrst_flags", {rx_val_64b, rx_st_64b, rx_end_64b, rx_dwen_64b, rx_err, rx_len_err}, 0);
        chk("midrst_words", log_w.size(), 0);
        send_seq(6, 16'h0000, 16'h0001, 16'h6000, 1); idle(3);
        pin_word("after_w0", 0, 64'h0000_0001_6002_6003, 3'b100);
        pin_word("after_w1", 1, 64'h6004_6005_0000_0000, 3'b011);

        clear_log();
        beat(0, 1, 16'h1234);
        idle(2);
        beat(1, 1, 16'h6abc);
        idle(3);
        chk("single_words", log_w.size(), 1);
        pin_word("single_w0", 0, 64'h6abc_0000_0000_0000, 3'b111);
        chk("single_err", errs, 2);
        chk("single_len", lens, LEN_ON);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
